// File: rtl/vx_om_lane_compactor.sv
// Splits one wide OM request into narrow OM beats, either packing active lanes
// densely or issuing fixed lane slices while skipping empty ones.
module vx_om_lane_compactor #(
  parameter int unsigned IN_LANES   = 4,
  parameter int unsigned OUT_LANES  = 1,
  parameter int unsigned COMPACT    = 1,
  parameter int unsigned UUID_WIDTH = 44,
  parameter int unsigned DIM_BITS   = 12,
  parameter int unsigned COLOR_BITS = 32,
  parameter int unsigned DEPTH_BITS = 24
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid_in,
  input  logic [UUID_WIDTH-1:0]            req_uuid_in,
  input  logic [IN_LANES-1:0]              req_mask_in,
  input  logic [IN_LANES*DIM_BITS-1:0]     req_pos_x_in,
  input  logic [IN_LANES*DIM_BITS-1:0]     req_pos_y_in,
  input  logic [IN_LANES*COLOR_BITS-1:0]   req_color_in,
  input  logic [IN_LANES*DEPTH_BITS-1:0]   req_depth_in,
  input  logic [IN_LANES-1:0]              req_face_in,
  output logic                             req_ready_in,
  output logic                             req_valid_out,
  output logic [UUID_WIDTH-1:0]            req_uuid_out,
  output logic [OUT_LANES-1:0]             req_mask_out,
  output logic [OUT_LANES*DIM_BITS-1:0]    req_pos_x_out,
  output logic [OUT_LANES*DIM_BITS-1:0]    req_pos_y_out,
  output logic [OUT_LANES*COLOR_BITS-1:0]  req_color_out,
  output logic [OUT_LANES*DEPTH_BITS-1:0]  req_depth_out,
  output logic [OUT_LANES-1:0]             req_face_out,
  output logic                             req_last_out,
  input  logic                             req_ready_out,
  output logic                             busy
);

  localparam int unsigned NUM_SLICES = IN_LANES / OUT_LANES;

  if (OUT_LANES < 1 || OUT_LANES > IN_LANES) begin : g_bad_out_lanes
    $error("OUT_LANES must be in 1..IN_LANES");
  end
  if (COMPACT == 0 && (IN_LANES % OUT_LANES) != 0) begin : g_bad_slicing
    $error("slice mode requires IN_LANES to be a multiple of OUT_LANES");
  end

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                          state;
  logic [UUID_WIDTH-1:0]           uuid_q;
  logic [IN_LANES-1:0]             rem_q;
  logic [IN_LANES*DIM_BITS-1:0]    pos_x_q;
  logic [IN_LANES*DIM_BITS-1:0]    pos_y_q;
  logic [IN_LANES*COLOR_BITS-1:0]  color_q;
  logic [IN_LANES*DEPTH_BITS-1:0]  depth_q;
  logic [IN_LANES-1:0]             face_q;
  logic [IN_LANES-1:0]             sel;
  logic                            found;
  logic                            fire_out;

  // Handshake: the next request can load in the same cycle the last beat leaves.
  assign req_valid_out = (state == ISSUE) & ~reset;
  assign busy          = (state == ISSUE) & ~reset;
  assign fire_out      = req_valid_out & req_ready_out;
  assign req_ready_in  = ~reset & ((state == IDLE) | (fire_out & req_last_out));
  assign req_uuid_out  = uuid_q;
  assign req_last_out  = ~|(rem_q & ~sel);

  // Beat formation from the remaining lanes of the held request.
  always_comb begin
    sel           = '0;
    found         = 1'b0;
    req_mask_out  = '0;
    req_pos_x_out = '0;
    req_pos_y_out = '0;
    req_color_out = '0;
    req_depth_out = '0;
    req_face_out  = '0;
    if (COMPACT != 0) begin
      for (int j = 0; j < OUT_LANES; j++) begin
        found = 1'b0;
        for (int i = 0; i < IN_LANES; i++) begin
          if (!found && rem_q[i] && !sel[i]) begin
            found           = 1'b1;
            sel[i]          = 1'b1;
            req_mask_out[j] = 1'b1;
            req_pos_x_out[j*DIM_BITS +: DIM_BITS]     = pos_x_q[i*DIM_BITS +: DIM_BITS];
            req_pos_y_out[j*DIM_BITS +: DIM_BITS]     = pos_y_q[i*DIM_BITS +: DIM_BITS];
            req_color_out[j*COLOR_BITS +: COLOR_BITS] = color_q[i*COLOR_BITS +: COLOR_BITS];
            req_depth_out[j*DEPTH_BITS +: DEPTH_BITS] = depth_q[i*DEPTH_BITS +: DEPTH_BITS];
            req_face_out[j] = face_q[i];
          end
        end
      end
    end else begin
      for (int s = 0; s < NUM_SLICES; s++) begin
        if (!found && (|rem_q[s*OUT_LANES +: OUT_LANES])) begin
          found = 1'b1;
          for (int j = 0; j < OUT_LANES; j++) begin
            if (rem_q[s*OUT_LANES + j]) begin
              sel[s*OUT_LANES + j] = 1'b1;
              req_mask_out[j]      = 1'b1;
              req_pos_x_out[j*DIM_BITS +: DIM_BITS] =
                pos_x_q[(s*OUT_LANES + j)*DIM_BITS +: DIM_BITS];
              req_pos_y_out[j*DIM_BITS +: DIM_BITS] =
                pos_y_q[(s*OUT_LANES + j)*DIM_BITS +: DIM_BITS];
              req_color_out[j*COLOR_BITS +: COLOR_BITS] =
                color_q[(s*OUT_LANES + j)*COLOR_BITS +: COLOR_BITS];
              req_depth_out[j*DEPTH_BITS +: DEPTH_BITS] =
                depth_q[(s*OUT_LANES + j)*DEPTH_BITS +: DEPTH_BITS];
              req_face_out[j] = face_q[s*OUT_LANES + j];
            end
          end
        end
      end
    end
  end

  // Holding register and lane cursor; an all-empty request is dropped on capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      rem_q <= '0;
    end else if (req_valid_in && req_ready_in) begin
      uuid_q  <= req_uuid_in;
      rem_q   <= req_mask_in;
      pos_x_q <= req_pos_x_in;
      pos_y_q <= req_pos_y_in;
      color_q <= req_color_in;
      depth_q <= req_depth_in;
      face_q  <= req_face_in;
      state   <= (|req_mask_in) ? ISSUE : IDLE;
    end else if (fire_out) begin
      rem_q <= rem_q & ~sel;
      if (req_last_out) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/vx_om_lane_compactor.md
Name: vx_om_lane_compactor

Overview:
- Width-converting successor to the OM request bus. Accepts one wide OM request of IN_LANES lanes and re-issues it as one or more narrow OM requests of OUT_LANES lanes.
- The wide request carries uuid, mask, pos_x, pos_y, color, depth and face per lane.
- In compact mode, masked-off lanes are squeezed out. In slice mode, all-empty slices are skipped.
- Sits between the core-side OM request bus and narrower OM units / memory-request generators. Adds a per-beat `last` flag so the consumer can detect request boundaries.

Parameters:
- IN_LANES, 4, lanes per input request (≥1).
- OUT_LANES, 1, lanes per output beat (1..IN_LANES).
- COMPACT, 1, 1 = pack active lanes densely; 0 = fixed slices of OUT_LANES, empty slices skipped. Requires IN_LANES % OUT_LANES == 0; elaboration error otherwise.
- UUID_WIDTH, 44, request tag width.
- DIM_BITS, 12, pos_x/pos_y width.
- COLOR_BITS, 32, color width (RGBA8).
- DEPTH_BITS, 24, depth width.

Ports:
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- req_valid_in, in, 1, input request valid.
- req_uuid_in, in, UUID_WIDTH, tag.
- req_mask_in, in, IN_LANES, active lanes.
- req_pos_x_in, in, IN_LANES*DIM_BITS, x per lane (lane 0 in LSBs).
- req_pos_y_in, in, IN_LANES*DIM_BITS, y per lane.
- req_color_in, in, IN_LANES*COLOR_BITS, color per lane.
- req_depth_in, in, IN_LANES*DEPTH_BITS, depth per lane.
- req_face_in, in, IN_LANES, face per lane.
- req_ready_in, out, 1, input accepted when valid&ready.
- req_valid_out, out, 1, output beat valid.
- req_uuid_out, out, UUID_WIDTH, tag copied from the input.
- req_mask_out, out, OUT_LANES, beat lane mask.
- req_pos_x_out, out, OUT_LANES*DIM_BITS, beat x per lane.
- req_pos_y_out, out, OUT_LANES*DIM_BITS, beat y per lane.
- req_color_out, out, OUT_LANES*COLOR_BITS, beat color per lane.
- req_depth_out, out, OUT_LANES*DEPTH_BITS, beat depth per lane.
- req_face_out, out, OUT_LANES, beat face per lane.
- req_last_out, out, 1, final beat of the current input request.
- busy, out, 1, holding register occupied.

Behaviour:
- Reset is synchronous. In any cycle with reset=1:
  - req_valid_out=0, busy=0, req_ready_in=0.
  - Holding register invalidated; lane cursor cleared.
  - Data outputs are don't-care.
- In the first cycle after reset: req_ready_in=1.
- Reset mid-burst discards remaining beats; no further beats of that request are emitted.
- Two states:
  - IDLE: holding register empty.
  - ISSUE: holding register full.
- req_ready_in = (state==IDLE) | (req_valid_out & req_ready_out_fire & req_last_out), where req_ready_out_fire is the consumer's ready.
  - A downstream ready input is implied: add port req_ready_out, in, 1.
  - A new request is therefore captured in the same cycle the last beat fires, giving zero bubble.
- Capture on input fire:
  - Store all fields.
  - remaining_mask = req_mask_in.
  - If req_mask_in==0, drop the request: the state stays or returns to IDLE and no beat is emitted.
  - Otherwise go to ISSUE.
- Latency: first beat valid the cycle after capture. Outputs are driven from registered state only; no combinational path from any *_in to any *_out.
- Beat formation, COMPACT=1:
  - Select the lowest-indexed set bits of remaining_mask, up to OUT_LANES of them, in ascending order.
  - Place them into out lanes 0..k-1; req_mask_out = (1<<k)-1.
  - Unused out lanes: data zero, mask 0.
- Beat formation, COMPACT=0:
  - Use the lowest slice s whose remaining_mask bits are nonzero.
  - Out lane j = in lane s*OUT_LANES+j.
  - req_mask_out = that slice's mask bits; lane positions are preserved.
- req_last_out=1 iff remaining_mask has no set bits beyond the current beat.
- On beat fire:
  - Clear the emitted bits from remaining_mask.
  - If last, go to IDLE (or reload from a simultaneous input capture).
- Stall stability: while req_valid_out & !req_ready_out, every *_out holds stable.
- uuid is identical on all beats of one request.
- Beat count: ceil(popcount(mask)/OUT_LANES) when COMPACT=1; number of non-empty slices when COMPACT=0.
- OUT_LANES==IN_LANES degenerates to a one-beat register slice. A request with nonzero mask produces exactly one beat with last=1.

Test Plan:
- IN=4, OUT=2, COMPACT=1, mask 4'b1011, pos_x={40,30,20,10} (lane3..0) -> beat0 mask 2'b11, pos_x {20,10}, last=0; beat1 mask 2'b01, pos_x lane0=40, last=1.
- Same stimulus with COMPACT=0 -> beat0 mask 2'b11 (lanes 0,1); beat1 mask 2'b10, lane1 pos_x=40, last=1.
- IN=4, OUT=1, mask 4'b0000 -> accepted (ready=1 for one valid cycle), zero output beats, busy stays 0.
- IN=4, OUT=1, mask 4'b1111, req_ready_out toggling 1,0,0,1... -> 4 beats, outputs stable during stalls; second request valid back-to-back is captured the cycle beat3 fires, and its beat0 appears the next cycle.
- IN=4, OUT=2, mask 4'b1111, assert reset after beat0 fires -> req_valid_out=0 during reset and after, no beat1 emitted; a new request is accepted post-reset.
- Random masks/ready, all modes (OUT in {1,2,4}) -> scoreboard matches the lane-order reference model; beat count and last flags are correct.
